// File: rtl/apb3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb3_rr_arbiter
// Description : Shares one APB3 master port between NUM_REQ requesters.
//               Each requester posts a 32-bit read or write command and holds
//               req until its own done pulse. Requesters are served
//               round-robin. The block runs the APB3 SETUP/ACCESS sequence
//               and returns rdata/error with a one-cycle one-hot done pulse.
//               An optional timeout aborts transfers to a hung slave.
// Parameters  : NUM_REQ     - number of requesters (2..8)
//               TIMEOUT_CYC - ACCESS wait cycles tolerated before abort,
//                             0 disables the timeout
// Ports       : pclk, presetn           clock, async active-low reset
//               req/req_write           per-requester request and direction
//               req_addr/req_wdata      packed commands, slice i = [32*i+:32]
//               done                    one-hot completion pulse
//               rsp_rdata/rsp_err       response, valid while done != 0
//               busy                    transfer in SETUP or ACCESS
//               psel/penable/pwrite/paddr/pwdata   APB3 master outputs
//               prdata/pready/pslverr              APB3 slave response
// Revision    : 1.0 - initial release
// ============================================================================
module apb3_rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     done,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [31:0]            paddr,
    output logic [31:0]            pwdata,
    input  logic [31:0]            prdata,
    input  logic                   pready,
    input  logic                   pslverr
);

    localparam int c_PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    // Pointer starts at the last index so requester 0 wins the first grant.
    localparam logic [c_PW-1:0] c_PTR_RST = c_PW'(NUM_REQ - 1);
    localparam logic [c_CW-1:0] c_TO      = c_CW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t               r_state,   w_state;
    logic [c_PW-1:0]      r_ptr,     w_ptr;
    logic [c_CW-1:0]      r_cnt,     w_cnt;
    logic                 r_psel,    w_psel;
    logic                 r_penable, w_penable;
    logic                 r_pwrite,  w_pwrite;
    logic [31:0]          r_paddr,   w_paddr;
    logic [31:0]          r_pwdata,  w_pwdata;
    logic [NUM_REQ-1:0]   r_done,    w_done;
    logic [31:0]          r_rdata,   w_rdata;
    logic                 r_err,     w_err;

    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_found;
    logic [c_PW-1:0]      w_win;

    // ------------------------------------------------------------------------
    // Next-state, grant and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_cnt     = r_cnt;
        w_psel    = r_psel;
        w_penable = r_penable;
        w_pwrite  = r_pwrite;
        w_paddr   = r_paddr;
        w_pwdata  = r_pwdata;
        w_done    = '0;
        w_rdata   = '0;
        w_err     = 1'b0;

        // The requester completing this cycle still has req high; masking
        // it with done keeps it from being re-granted before it can drop.
        w_elig  = req & ~r_done;
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && w_elig[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = c_PW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end

        case (r_state)
            S_IDLE: begin
                w_psel    = 1'b0;
                w_penable = 1'b0;
                if (w_found) begin
                    w_state  = S_SETUP;
                    w_ptr    = w_win;
                    w_cnt    = '0;
                    w_psel   = 1'b1;
                    w_pwrite = req_write[w_win];
                    w_paddr  = req_addr[int'(w_win)*32 +: 32];
                    w_pwdata = req_wdata[int'(w_win)*32 +: 32];
                end
            end

            S_SETUP: begin
                w_penable = 1'b1;
                w_state   = S_ACCESS;
            end

            S_ACCESS: begin
                if (pready) begin
                    // Normal completion wins even on the timeout cycle.
                    w_psel         = 1'b0;
                    w_penable      = 1'b0;
                    w_done[r_ptr]  = 1'b1;
                    w_rdata        = r_pwrite ? 32'd0 : prdata;
                    w_err          = pslverr;
                    w_state        = S_IDLE;
                end else if (TIMEOUT_CYC > 0) begin
                    if (r_cnt == c_TO) begin
                        w_psel        = 1'b0;
                        w_penable     = 1'b0;
                        w_done[r_ptr] = 1'b1;
                        w_err         = 1'b1;
                        w_state       = S_IDLE;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state   = S_IDLE;
                w_psel    = 1'b0;
                w_penable = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state   <= S_IDLE;
            r_ptr     <= c_PTR_RST;
            r_cnt     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_cnt     <= w_cnt;
            r_psel    <= w_psel;
            r_penable <= w_penable;
            r_pwrite  <= w_pwrite;
            r_paddr   <= w_paddr;
            r_pwdata  <= w_pwdata;
            r_done    <= w_done;
            r_rdata   <= w_rdata;
            r_err     <= w_err;
        end
    end

    assign done      = r_done;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign busy      = (r_state != S_IDLE);
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;

endmodule
`default_nettype wire
